// File: rtl/mem_ctrl.sv
// mem_ctrl: arbiter and byte sequencer for the shared byte-wide RAM/IO bus.
// MEM requests have priority over instruction fetch. Multi-byte accesses are
// split into per-byte bus cycles, and loads are assembled little-endian.
// Optional feature macro: MEM_CTRL_FETCH_ABORT_EN. When it is defined, flush_in
// aborts an in-flight fetch.
module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  input  logic        flush_in,
  output logic        if_done_out,
  output logic [31:0] if_inst_out,
  input  logic        mem_req_in,
  input  logic        mem_we_in,
  input  logic [1:0]  mem_size_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] mem_wdata_in,
  output logic        mem_done_out,
  output logic [31:0] mem_rdata_out,
  input  logic [7:0]  ram_din_in,
  output logic [7:0]  ram_dout_out,
  output logic [31:0] ram_a_out,
  output logic        ram_wr_out
);

`ifdef MEM_CTRL_FETCH_ABORT_EN
  localparam bit FetchAbort = 1'b1;
`else
  localparam bit FetchAbort = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic        own_mem_q, own_mem_d;  // 1: MEM owns the transaction, 0: fetch
  logic [2:0]  n_q, n_d;              // bytes in the transaction (1/2/4)
  logic [2:0]  cnt_q, cnt_d;          // bytes issued (read) or written (write)
  logic [2:0]  rcnt_q, rcnt_d;        // bytes captured (read)
  logic        pend_q, pend_d;        // a read byte was issued last cycle
  logic [31:0] data_q, data_d;
  logic [31:0] wdata_q, wdata_d;      // remaining store bytes, next one in [7:0]
  logic [31:0] ram_a_q, ram_a_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic        wstb_q, wstb_d;
  logic        if_done_q, if_done_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        mem_done_q, mem_done_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [2:0]  mem_n;

  assign mem_n = (mem_size_in == 2'b00) ? 3'd1 :
                 (mem_size_in == 2'b01) ? 3'd2 : 3'd4;

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    own_mem_d   = own_mem_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    rcnt_d      = rcnt_q;
    pend_d      = pend_q;
    data_d      = data_q;
    wdata_d     = wdata_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    wstb_d      = wstb_q;
    if_done_d   = 1'b0;
    if_inst_d   = if_inst_q;
    mem_done_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;

    unique case (state_q)
      StIdle: begin
        ram_a_d    = '0;
        ram_dout_d = '0;
        wstb_d     = 1'b0;
        if (rdy_in) begin
          if (mem_req_in) begin
            own_mem_d = 1'b1;
            n_d       = mem_n;
            cnt_d     = '0;
            rcnt_d    = '0;
            pend_d    = 1'b0;
            data_d    = '0;
            ram_a_d   = mem_addr_in;
            if (mem_we_in) begin
              ram_dout_d = mem_wdata_in[7:0];
              wdata_d    = {8'h00, mem_wdata_in[31:8]};
              wstb_d     = 1'b1;
              state_d    = StWrite;
            end else begin
              state_d = StRead;
            end
          end else if (if_req_in && !(FetchAbort && flush_in)) begin
            own_mem_d = 1'b0;
            n_d       = 3'd4;
            cnt_d     = '0;
            rcnt_d    = '0;
            pend_d    = 1'b0;
            data_d    = '0;
            ram_a_d   = if_addr_in;
            state_d   = StRead;
          end
        end
      end

      StRead: begin
        // The byte issued last cycle is captured even while the bus is paused.
        if (pend_q) begin
          data_d[{rcnt_q[1:0], 3'b000} +: 8] = ram_din_in;
          rcnt_d = rcnt_q + 3'd1;
          pend_d = 1'b0;
        end
        if (rdy_in) begin
          if (cnt_q < n_q) begin
            pend_d = 1'b1;
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q + 3'd1 < n_q) begin
              ram_a_d = ram_a_q + 32'd1;
            end
          end else if (rcnt_d == n_q) begin
            state_d = StDone;
            ram_a_d = '0;
            if (own_mem_q) begin
              mem_done_d  = 1'b1;
              mem_rdata_d = data_d;
            end else begin
              if_done_d = 1'b1;
              if_inst_d = data_d;
            end
          end
        end
        if (FetchAbort && !own_mem_q && flush_in) begin
          state_d = StIdle;
          ram_a_d = '0;
          pend_d  = 1'b0;
        end
      end

      StWrite: begin
        if (rdy_in) begin
          if (cnt_q + 3'd1 < n_q) begin
            cnt_d      = cnt_q + 3'd1;
            ram_a_d    = ram_a_q + 32'd1;
            ram_dout_d = wdata_q[7:0];
            wdata_d    = {8'h00, wdata_q[31:8]};
          end else begin
            state_d    = StDone;
            wstb_d     = 1'b0;
            ram_a_d    = '0;
            ram_dout_d = '0;
            mem_done_d = 1'b1;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs, with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      own_mem_q   <= 1'b0;
      n_q         <= '0;
      cnt_q       <= '0;
      rcnt_q      <= '0;
      pend_q      <= 1'b0;
      data_q      <= '0;
      wdata_q     <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      wstb_q      <= 1'b0;
      if_done_q   <= 1'b0;
      if_inst_q   <= '0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      own_mem_q   <= own_mem_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      rcnt_q      <= rcnt_d;
      pend_q      <= pend_d;
      data_q      <= data_d;
      wdata_q     <= wdata_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      wstb_q      <= wstb_d;
      if_done_q   <= if_done_d;
      if_inst_q   <= if_inst_d;
      mem_done_q  <= mem_done_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_a_out     = ram_a_q;
  assign ram_dout_out  = ram_dout_q;
  assign ram_wr_out    = wstb_q & rdy_in;
  assign if_done_out   = if_done_q;
  assign if_inst_out   = if_inst_q;
  assign mem_done_out  = mem_done_q;
  assign mem_rdata_out = mem_rdata_q;

endmodule
